// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: snapshot memory for the time-interleaved ADC array.
// Arm plus trigger starts a capture of 2^N_mem_addr frames. Software reads
// the frames back one lane sample at a time.
// Optional build macro: ADC_CAPTURE_DECIMATE_EN adds a decim[3:0] input.
// With it, only every (decim+1)-th valid frame is stored.
module adc_capture_buffer #(
    parameter int unsigned Nti        = 16,
    parameter int unsigned Nadc       = 8,
    parameter int unsigned N_mem_addr = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [Nti*Nadc-1:0]     in_frame,
    input  logic                    in_valid,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    trig_mode,
    input  logic                    ext_trig,
`ifdef ADC_CAPTURE_DECIMATE_EN
    input  logic [3:0]              decim,
`endif
    input  logic [N_mem_addr-1:0]   rd_addr,
    input  logic [$clog2(Nti)-1:0]  rd_lane,
    output logic [Nadc-1:0]         rd_sample,
    output logic                    busy,
    output logic                    done,
    output logic [N_mem_addr:0]     wr_count
);

    localparam int unsigned DEPTH = 2 ** N_mem_addr;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t                       state;
    logic [N_mem_addr-1:0]        wr_ptr;
    logic [Nti-1:0][Nadc-1:0]     mem [DEPTH];

    logic trig_c;
    logic take_c;
    logic we_c;
    logic last_c;

`ifdef ADC_CAPTURE_DECIMATE_EN
    logic [3:0] decim_q;
    logic [3:0] skip_cnt;

    // Store a frame once decim_q frames have been skipped since the last stored frame.
    assign take_c = (skip_cnt == decim_q);
`else
    assign take_c = 1'b1;
`endif

    // The trigger frame is itself stored at address 0 in the same cycle.
    assign trig_c = in_valid && (!trig_mode || ext_trig);
    assign last_c = &wr_ptr;
    assign we_c   = !rst && !abort && in_valid &&
                    (((state == ARMED) && (!trig_mode || ext_trig)) ||
                     ((state == CAPTURE) && take_c));

    // Capture control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            wr_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ADC_CAPTURE_DECIMATE_EN
            decim_q  <= '0;
            skip_cnt <= '0;
`endif
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state    <= ARMED;
                        wr_ptr   <= '0;
                        wr_count <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
`ifdef ADC_CAPTURE_DECIMATE_EN
                        skip_cnt <= '0;
`endif
                    end
                end
                ARMED: begin
                    if (trig_c) begin
                        state    <= CAPTURE;
                        wr_ptr   <= wr_ptr + N_mem_addr'(1);
                        wr_count <= wr_count + (N_mem_addr + 1)'(1);
`ifdef ADC_CAPTURE_DECIMATE_EN
                        decim_q  <= decim;
                        skip_cnt <= '0;
`endif
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
`ifdef ADC_CAPTURE_DECIMATE_EN
                        skip_cnt <= take_c ? 4'd0 : skip_cnt + 4'd1;
`endif
                        if (take_c) begin
                            wr_ptr   <= wr_ptr + N_mem_addr'(1);
                            wr_count <= wr_count + (N_mem_addr + 1)'(1);
                            if (last_c) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frame memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wr_ptr] <= in_frame;
        end
    end

    // Registered lane readback. A same-cycle write returns the old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sample <= '0;
        end else if (32'(rd_lane) < Nti) begin
            rd_sample <= mem[rd_addr][rd_lane];
        end else begin
            rd_sample <= '0;
        end
    end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized self-checking bench for adc_capture_buffer.
// The expected memory image is built from the capture rules (frame index
// relative to the trigger, decimation step, depth limit).
module tb_adc_capture_buffer;

    localparam int unsigned NTI   = 16;
    localparam int unsigned NADC  = 8;
    localparam int unsigned NA    = 10;
    localparam int unsigned DEPTH = 1 << NA;
    localparam int unsigned FW    = NTI * NADC;

    logic            clk = 1'b0;
    logic            rst;
    logic [FW-1:0]   in_frame;
    logic            in_valid;
    logic            arm;
    logic            abort;
    logic            trig_mode;
    logic            ext_trig;
`ifdef ADC_CAPTURE_DECIMATE_EN
    logic [3:0]      decim;
`endif
    logic [NA-1:0]   rd_addr;
    logic [3:0]      rd_lane;
    logic [NADC-1:0] rd_sample;
    logic            busy;
    logic            done;
    logic [NA:0]     wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [FW-1:0] exp_mem [DEPTH];

    adc_capture_buffer #(.Nti(NTI), .Nadc(NADC), .N_mem_addr(NA)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_frame  (in_frame),
        .in_valid  (in_valid),
        .arm       (arm),
        .abort     (abort),
        .trig_mode (trig_mode),
        .ext_trig  (ext_trig),
`ifdef ADC_CAPTURE_DECIMATE_EN
        .decim     (decim),
`endif
        .rd_addr   (rd_addr),
        .rd_lane   (rd_lane),
        .rd_sample (rd_sample),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        arm      = 1'b0;
        abort    = 1'b0;
        ext_trig = 1'b0;
    endtask

    function automatic logic [FW-1:0] rand_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [FW-1:0] pattern_frame(input int idx);
        logic [FW-1:0] f;
        for (int k = 0; k < int'(NTI); k++) f[k*NADC +: NADC] = 8'((idx + k) % 256);
        return f;
    endfunction

    task automatic read_chk(input string tag, input int a, input int l);
        logic [FW-1:0] f;
        f       = exp_mem[a];
        rd_addr = NA'(a);
        rd_lane = 4'(l);
        tick();
        check(tag, 64'(rd_sample), 64'(f[l*NADC +: NADC]));
    endtask

    task automatic read_rand(input string tag, input int n, input int lim);
        for (int i = 0; i < n; i++) read_chk(tag, $urandom_range(0, lim - 1), $urandom_range(0, NTI - 1));
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Feeds frames until done or budget; records what each address should hold.
    task automatic capture(input int trig_at, input int gap, input int step, input bit pat,
                           input int budget, output int vcount, output int cyc);
        logic [FW-1:0] f;
        bit bad_busy;
        int n;
        vcount   = 0;
        cyc      = 0;
        bad_busy = 0;
        while (!done && cyc < budget) begin
            f        = pat ? pattern_frame(cyc) : rand_frame();
            in_frame = f;
            in_valid = (cyc % gap) == 0;
            ext_trig = in_valid && (vcount == trig_at);
            arm      = ($urandom_range(0, 3) == 0);
`ifdef ADC_CAPTURE_DECIMATE_EN
            decim = (vcount > trig_at && step > 1) ? 4'($urandom) : 4'(step - 1);
`endif
            if (in_valid) begin
                if (vcount >= trig_at && ((vcount - trig_at) % step) == 0) begin
                    n = (vcount - trig_at) / step;
                    if (n < int'(DEPTH)) exp_mem[n] = f;
                end
                vcount++;
            end
            tick();
            cyc++;
            if (!done && !busy) bad_busy = 1;
        end
        drive_idle();
        check("busy_during_capture", 64'(bad_busy), 64'(0));
    endtask

    initial begin
        int vc, cy;
        rst       = 1'b1;
        in_frame  = '0;
        trig_mode = 1'b0;
        rd_addr   = '0;
        rd_lane   = '0;
`ifdef ADC_CAPTURE_DECIMATE_EN
        decim = 4'd0;
`endif
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_wr_count", 64'(wr_count), 64'(0));
        check("rst_rd_sample", 64'(rd_sample), 64'(0));

        // Immediate capture with the lane-index pattern.
        trig_mode = 1'b0;
        do_arm();
        check("imm_armed_busy", 64'(busy), 64'(1));
        capture(0, 1, 1, 1'b1, 1100, vc, cy);
        check("imm_frames_to_done", 64'(vc), 64'(1024));
        for (int i = cy; i < 1100; i++) begin
            in_frame = rand_frame();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("imm_done", 64'(done), 64'(1));
        check("imm_busy", 64'(busy), 64'(0));
        check("imm_wr_count", 64'(wr_count), 64'(1024));
        read_chk("imm_a5_l3", 5, 3);
        check("imm_a5_l3_value", 64'(rd_sample), 64'(8));
        read_chk("imm_a6_l3", 6, 3);
        check("imm_a6_l3_value", 64'(rd_sample), 64'(9));
        read_rand("imm_read", 8, DEPTH);

        // External trigger on valid frame 50.
        trig_mode = 1'b1;
        do_arm();
        capture(50, 1, 1, 1'b0, 3000, vc, cy);
        check("ext_frames_to_done", 64'(vc), 64'(1074));
        check("ext_done", 64'(done), 64'(1));
        check("ext_wr_count", 64'(wr_count), 64'(1024));
        for (int l = 0; l < int'(NTI); l += 5) read_chk("ext_addr0", 0, l);
        read_rand("ext_read", 10, DEPTH);

        // Alternating valid during capture.
        trig_mode = 1'b0;
        do_arm();
        capture(0, 2, 1, 1'b0, 5000, vc, cy);
        check("gap_valid_frames", 64'(vc), 64'(1024));
        check("gap_cycles_to_last_write", 64'(cy), 64'(2047));
        check("gap_done", 64'(done), 64'(1));
        read_chk("gap_last", 1023, 7);
        read_rand("gap_read", 10, DEPTH);

        // Abort after 300 writes; the abort-cycle frame must not land.
        do_arm();
        capture(0, 1, 1, 1'b0, 300, vc, cy);
        check("abort_pre_count", 64'(wr_count), 64'(300));
        abort    = 1'b1;
        in_valid = 1'b1;
        in_frame = rand_frame();
        tick();
        drive_idle();
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_wr_count", 64'(wr_count), 64'(300));
        read_chk("abort_a299", 299, 2);
        read_chk("abort_a300_untouched", 300, 9);
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        drive_idle();
        check("abort_arm_busy", 64'(busy), 64'(0));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_frame = rand_frame();
            tick();
        end
        in_valid = 1'b0;
        check("abort_idle_busy", 64'(busy), 64'(0));
        check("abort_idle_count", 64'(wr_count), 64'(300));

        // Reset mid-capture, then full capture and re-arm from DONE.
        do_arm();
        capture(0, 1, 1, 1'b0, 100, vc, cy);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        check("rst_mid_wr_count", 64'(wr_count), 64'(0));
        read_chk("rst_mid_a50", 50, 4);
        read_chk("rst_mid_a100", 100, 11);
        do_arm();
        capture(0, 1, 1, 1'b0, 1100, vc, cy);
        check("rearm_pre_done", 64'(done), 64'(1));
        do_arm();
        check("rearm_busy", 64'(busy), 64'(1));
        check("rearm_done", 64'(done), 64'(0));
        check("rearm_wr_count", 64'(wr_count), 64'(0));
        capture(0, 1, 1, 1'b0, 5, vc, cy);
        check("rearm_wr_count5", 64'(wr_count), 64'(5));
        for (int a = 0; a < 6; a++) read_chk("rearm_read", a, $urandom_range(0, NTI - 1));

`ifdef ADC_CAPTURE_DECIMATE_EN
        // Decimate by 4 with decim changing after the trigger.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        decim = 4'd3;
        do_arm();
        capture(0, 1, 4, 1'b0, 6000, vc, cy);
        check("decim_frames_to_done", 64'(vc), 64'(4093));
        check("decim_wr_count", 64'(wr_count), 64'(1024));
        read_rand("decim_read", 12, DEPTH);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
